sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sync_fifo_mem.sv | 23 ++
 rtl/sync_fifo.sv | 119 +++++++++++
 tb/tb_sync_fifo.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered flags, standard or first-word-fall-through read.
// Define SYNC_FIFO_ERR_EN to enable the sticky overflow/underflow flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        r_en,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_TH);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and >= 2");
  end
  if (!(AEMPTY_TH > 0 && AEMPTY_TH < AFULL_TH && AFULL_TH < DEPTH)) begin : g_bad_thresh
    $error("sync_fifo: need 0 < AEMPTY_TH < AFULL_TH < DEPTH");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]         count_nxt;
  logic                  wr_acc, rd_acc;
  logic [AW-1:0]         mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata, head_nxt;

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_comb begin
    rd_ptr_nxt = rd_ptr + PW'(rd_acc);
    count_nxt  = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    // FWFT prefetches the word that will be at the head after this edge;
    // if that slot is being written right now, bypass the memory.
    mem_raddr = (MODE == FIFO_FWFT) ? rd_ptr_nxt[AW-1:0] : rd_ptr[AW-1:0];
    head_nxt  = (wr_acc && (rd_ptr_nxt == wr_ptr)) ? data_in : mem_rdata;
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      data_out     <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= (count_nxt == FULL_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      if (MODE == FIFO_STD) begin
        if (rd_acc) data_out <= mem_rdata;
      end else if (count_nxt != '0) begin
        data_out <= head_nxt;
      end
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench: standard and FWFT instances driven with identical directed stimulus.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, w_en, r_en;
  logic [7:0] data_in;

  logic [7:0] dout_s, dout_f;
  logic [4:0] cnt_s, cnt_f;
  logic full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic full_f, empty_f, af_f, ae_f, ovf_f, unf_f;

  always #5 clk = ~clk;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(cnt_s), .overflow(ovf_s), .underflow(unf_s));

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ovf_f), .underflow(unf_f));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_s[$];
  logic [7:0] exp_f[$];
  bit m_ovf, m_unf;
  bit std_fire = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard mode: data appears the cycle after an accepted read.
  always @(posedge clk) std_fire <= !rst && r_en && !empty_s;

  always @(negedge clk) begin
    if (std_fire) begin
      if (exp_s.size() == 0) chk("std_q_underrun", 32'd1, 32'd0);
      else chk("std_data", {24'd0, dout_s}, {24'd0, exp_s.pop_front()});
    end
  end

  // FWFT: head word must be on data_out while a read is being accepted.
  always @(negedge clk) begin
    if (!rst && r_en && !empty_f) begin
      if (exp_f.size() == 0) chk("fwft_q_underrun", 32'd1, 32'd0);
      else chk("fwft_data", {24'd0, dout_f}, {24'd0, exp_f.pop_front()});
    end
  end

  task automatic check_state();
    int n;
    n = mq.size();
    chk("std_count",  {27'd0, cnt_s}, n);
    chk("fwft_count", {27'd0, cnt_f}, n);
    chk("std_full",   full_s,  n == 16);
    chk("fwft_full",  full_f,  n == 16);
    chk("std_empty",  empty_s, n == 0);
    chk("fwft_empty", empty_f, n == 0);
    chk("std_afull",  af_s,    n >= 14);
    chk("fwft_afull", af_f,    n >= 14);
    chk("std_aempty", ae_s,    n <= 2);
    chk("fwft_aempty",ae_f,    n <= 2);
    chk("std_ovf",    ovf_s,   m_ovf);
    chk("fwft_ovf",   ovf_f,   m_ovf);
    chk("std_unf",    unf_s,   m_unf);
    chk("fwft_unf",   unf_f,   m_unf);
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r);
    bit wa, ra;
    wa = w && (mq.size() < 16);
    ra = r && (mq.size() > 0);
    if (w && mq.size() == 16) m_ovf = ERR;
    if (r && mq.size() == 0)  m_unf = ERR;
    if (ra) begin
      exp_s.push_back(mq[0]);
      exp_f.push_back(mq[0]);
    end
    w_en = w; data_in = d; r_en = r;
    @(posedge clk);
    if (ra) void'(mq.pop_front());
    if (wa) mq.push_back(d);
    #1;
    w_en = 1'b0; r_en = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    rst = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
    @(posedge clk);
    mq.delete(); exp_s.delete(); exp_f.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
    check_state();
    chk("std_rst_dout",  {24'd0, dout_s}, 32'd0);
    chk("fwft_rst_dout", {24'd0, dout_f}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    do_reset();

    // Fill to full, then attempt a write into the full FIFO
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fwft_head_after_fill", {24'd0, dout_f}, 32'h00);
    step(1'b1, 8'hAA, 1'b0);

    // Drain, then read once more while empty
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("fwft_hold_empty", {24'd0, dout_f}, 32'h0F);
    chk("std_hold_empty",  {24'd0, dout_s}, 32'h0F);

    // Steady-state streaming at half occupancy, pointers wrap twice
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'h40 + 8'(i), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Write into empty FIFO: FWFT shows it without a read
    do_reset();
    step(1'b1, 8'h5A, 1'b1);
    chk("fwft_fallthrough", {24'd0, dout_f}, 32'h5A);
    chk("std_no_fallthrough", {24'd0, dout_s}, 32'h00);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("fwft_hold_5a", {24'd0, dout_f}, 32'h5A);

    // Reset mid-operation with w_en and r_en high
    for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    do_reset();
    step(1'b0, 8'h00, 1'b0);

    chk("std_q_leftover",  exp_s.size(), 32'd0);
    chk("fwft_q_leftover", exp_f.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
